aes_bus_master: RTL and testbench

- Host-side initiator for the AES128 chip's 32-bit shared bus. It drives the RW/adress/initiate/data bus the chip responds on.
- Accepts a 128-bit key, a 128-bit block and a mode bit from a local requester through a valid/ready handshake.
- Writes key and block to the chip as 32-bit words, pulses start, then waits a fixed compute latency.
- Reads the 128-bit result back and presents it with a one-cycle valid.

---
 rtl/aes_bus_master_if.sv | 30 +++
 rtl/aes_bus_master.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_bus_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_bus_master_if.sv
// Requester handshake plus AES chip control strobes for aes_bus_master.
// The shared 32-bit data bus stays a plain inout on the master, so its
// tri-state driver sits directly on a module port.
interface aes_bus_master_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_block;
  logic         req_decrypt;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         busy;
  logic         selCypher;
  logic         start;
  logic         RW;
  logic         adress;
  logic         initiate;

  modport master (
    input  req_valid, req_key, req_block, req_decrypt,
    output req_ready, rsp_valid, rsp_data, busy,
    output selCypher, start, RW, adress, initiate
  );

  modport slave (
    output req_valid, req_key, req_block, req_decrypt,
    input  req_ready, rsp_valid, rsp_data, busy,
    input  selCypher, start, RW, adress, initiate
  );
endinterface

// File: rtl/aes_bus_master.sv
// Host-side initiator for the AES128 chip bus: writes key and block as
// 32-bit words, pulses start, waits LATENCY cycles, reads four result
// words back and presents them with a one-cycle rsp_valid.
// Word 0 of every 128-bit value is its most significant 32 bits.
module aes_bus_master #(
  parameter int LATENCY   = 12,
  parameter int KEY_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  aes_bus_master_if.master bus,
  inout  wire  [31:0]      data
);

  localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);
  localparam logic       KEY_IN_A  = (KEY_FIRST != 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_A    = 3'd1,
    ST_WR_B    = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_RD      = 3'd5,
    ST_RD_TAIL = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [1:0]    word_r;
  logic [1:0]    word_next_s;
  logic [7:0]    cnt_r;
  logic [7:0]    cnt_next_s;
  logic          accept_s;

  logic [127:0]  key_r;
  logic [127:0]  block_r;
  logic          sel_r;
  logic [95:0]   result_r;
  logic [127:0]  rsp_data_r;

  logic          req_ready_r;
  logic          busy_r;
  logic          rsp_valid_r;
  logic          start_r;
  logic          rw_r;
  logic          adress_r;
  logic          initiate_r;
  logic          drive_r;
  logic [31:0]   wdata_r;

  logic          wr_phase_s;
  logic          key_phase_s;
  logic [127:0]  key_src_s;
  logic [127:0]  blk_src_s;
  logic [31:0]   wdata_next_s;

  // Select 32-bit word idx (0 = most significant) of a 128-bit value.
  function automatic logic [31:0] word_sel(input logic [127:0] vec, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = vec[127:96];
      2'd1:    w = vec[95:64];
      2'd2:    w = vec[63:32];
      2'd3:    w = vec[31:0];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Next-state logic, plus the bus outputs belonging to the state being entered.
  always_comb begin
    state_next_s = state_r;
    word_next_s  = word_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_r) begin
          accept_s     = 1'b1;
          state_next_s = ST_WR_A;
          word_next_s  = 2'd0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WR_A: begin
        if (word_r == 2'd3) begin
          state_next_s = ST_WR_B;
          word_next_s  = 2'd0;
        end else begin
          word_next_s  = word_r + 2'd1;
        end
      end
      ST_WR_B: begin
        if (word_r == 2'd3) begin
          state_next_s = ST_START;
          word_next_s  = 2'd0;
        end else begin
          word_next_s  = word_r + 2'd1;
        end
      end
      ST_START: begin
        state_next_s = ST_WAIT;
        cnt_next_s   = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_r == 8'd0) begin
          state_next_s = ST_RD;
          word_next_s  = 2'd0;
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
        end
      end
      ST_RD: begin
        if (word_r == 2'd3) begin
          state_next_s = ST_RD_TAIL;
          word_next_s  = 2'd0;
        end else begin
          word_next_s  = word_r + 2'd1;
        end
      end
      ST_RD_TAIL: begin
        state_next_s = ST_DONE;
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        word_next_s  = 2'd0;
        cnt_next_s   = 8'd0;
      end
    endcase

    // On the accept edge the key/block registers are not loaded yet,
    // so the first word comes straight from the request inputs.
    if (accept_s) begin
      key_src_s = bus.req_key;
      blk_src_s = bus.req_block;
    end else begin
      key_src_s = key_r;
      blk_src_s = block_r;
    end

    wr_phase_s  = (state_next_s == ST_WR_A) || (state_next_s == ST_WR_B);
    key_phase_s = wr_phase_s && ((state_next_s == ST_WR_A) == KEY_IN_A);
    if (key_phase_s) begin
      wdata_next_s = word_sel(key_src_s, word_next_s);
    end else begin
      wdata_next_s = word_sel(blk_src_s, word_next_s);
    end
  end

  // State register and registered bus/handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      word_r      <= 2'd0;
      cnt_r       <= 8'd0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      start_r     <= 1'b0;
      rw_r        <= 1'b0;
      adress_r    <= 1'b0;
      initiate_r  <= 1'b0;
      drive_r     <= 1'b0;
      wdata_r     <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      word_r      <= word_next_s;
      cnt_r       <= cnt_next_s;
      req_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      rsp_valid_r <= (state_next_s == ST_DONE);
      start_r     <= (state_next_s == ST_START);
      rw_r        <= wr_phase_s;
      adress_r    <= key_phase_s;
      initiate_r  <= wr_phase_s || (state_next_s == ST_RD);
      drive_r     <= wr_phase_s;
      wdata_r     <= wdata_next_s;
    end
  end

  // Latch the job and the mode bit when a request is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_r   <= 128'd0;
      block_r <= 128'd0;
      sel_r   <= 1'b0;
    end else if (accept_s) begin
      key_r   <= bus.req_key;
      block_r <= bus.req_block;
      sel_r   <= bus.req_decrypt;
    end
  end

  // Capture read words one cycle after each strobe; the last lands in RD_TAIL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_r   <= 96'd0;
      rsp_data_r <= 128'd0;
    end else begin
      if ((state_r == ST_RD) && (word_r != 2'd0)) begin
        result_r <= {result_r[63:0], data};
      end
      if (state_r == ST_RD_TAIL) begin
        rsp_data_r <= {result_r, data};
      end
    end
  end

  assign data          = drive_r ? wdata_r : {32{1'bz}};
  assign bus.req_ready = req_ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.selCypher = sel_r;
  assign bus.start     = start_r;
  assign bus.RW        = rw_r;
  assign bus.adress    = adress_r;
  assign bus.initiate  = initiate_r;

endmodule

// File: tb/tb_aes_bus_master.sv
// Directed bench for aes_bus_master with a behavioural AES chip stub that
// answers the FIPS-197 example vectors.
module tb_aes_bus_master;

  localparam int           LAT = 12;
  localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_bus_master_if bi();
  aes_bus_master_if bi2();
  wire [31:0] data1;
  wire [31:0] data2;

  aes_bus_master #(.LATENCY(LAT), .KEY_FIRST(1)) dut (
    .clk(clk), .reset(reset), .bus(bi), .data(data1)
  );
  aes_bus_master #(.LATENCY(LAT), .KEY_FIRST(0)) dut_kf0 (
    .clk(clk), .reset(reset), .bus(bi2), .data(data2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- chip stub ----------------
  logic [127:0] ck, cm, cres;
  logic [1:0]   kp, mp, rp;
  logic         chip_oe;
  logic [31:0]  chip_word;

  assign data1 = chip_oe ? chip_word : {32{1'bz}};

  function automatic logic [127:0] chip_calc(input logic [127:0] key, input logic [127:0] msg,
                                             input logic dec);
    if (key == K && !dec && msg == P) return C;
    else if (key == K && dec && msg == C) return P;
    else return key ^ msg;
  endfunction

  // Chip: store written words, compute on start, answer reads one cycle later.
  always @(posedge clk) begin
    if (!reset) begin
      kp <= 2'd0; mp <= 2'd0; rp <= 2'd0;
      chip_oe <= 1'b0; chip_word <= 32'd0;
    end else begin
      chip_oe <= 1'b0;
      if (bi.initiate && bi.RW && bi.adress) begin
        ck[127 - 32*int'(kp) -: 32] <= data1;
        kp <= kp + 2'd1;
      end
      if (bi.initiate && bi.RW && !bi.adress) begin
        cm[127 - 32*int'(mp) -: 32] <= data1;
        mp <= mp + 2'd1;
      end
      if (bi.initiate && !bi.RW) begin
        chip_oe   <= 1'b1;
        chip_word <= cres[127 - 32*int'(rp) -: 32];
        rp        <= rp + 2'd1;
      end
      if (bi.start) begin
        cres <= chip_calc(ck, cm, bi.selCypher);
        kp <= 2'd0; mp <= 2'd0; rp <= 2'd0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int   cyc = 0;
  int   zbad = 0;
  int   overlap = 0;
  int   rsp_cnt = 0;
  logic tr_adr[$];
  logic [31:0] tr_dat[$];
  int   tr_cyc[$];
  int   st_cyc[$];
  int   rd_cyc[$];
  logic tr2_adr[$];
  logic [31:0] tr2_dat[$];
  logic released1;

  assign released1 = $isunknown(data1) || (data1 == 32'h0);

  // Cycle counter for trace timestamps.
  always @(posedge clk) cyc <= cyc + 1;

  // Record write traces, strobes and bus-rule violations between edges.
  always @(negedge clk) begin
    if (bi.initiate && bi.RW) begin
      tr_adr.push_back(bi.adress);
      tr_dat.push_back(data1);
      tr_cyc.push_back(cyc);
    end
    if (bi.initiate && !bi.RW) rd_cyc.push_back(cyc);
    if (bi.start) st_cyc.push_back(cyc);
    if (bi.initiate && bi.start) overlap <= overlap + 1;
    if (!bi.RW && !chip_oe && !released1) zbad <= zbad + 1;
    if (bi.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (bi2.initiate && bi2.RW) begin
      tr2_adr.push_back(bi2.adress);
      tr2_dat.push_back(data2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic present(input logic [127:0] key, input logic [127:0] blk, input logic dec);
    bi.req_key = key;  bi.req_block = blk;  bi.req_decrypt = dec;  bi.req_valid = 1'b1;
    bi2.req_key = key; bi2.req_block = blk; bi2.req_decrypt = dec; bi2.req_valid = 1'b1;
  endtask

  task automatic drop_valid();
    bi.req_valid = 1'b0;
    bi2.req_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ctrl"}, {bi.req_ready, bi.rsp_valid, bi.busy, bi.selCypher,
                         bi.start, bi.RW, bi.adress, bi.initiate}, 128'(8'b1000_0000));
    chk({tag, "_data"}, bi.rsp_data, 128'd0);
    chk({tag, "_bus_z"}, 128'(released1), 128'd1);
  endtask

  // Called at a negedge with the DUT idle; that negedge is cycle 0.
  task automatic run_job(input string tag, input logic [127:0] key, input logic [127:0] blk,
                         input logic dec, input logic [127:0] exp);
    int n;
    int selbad;
    n = 0;
    selbad = 0;
    present(key, blk, dec);
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) drop_valid();
      if (bi.busy && (bi.selCypher !== dec)) selbad++;
      if (bi.rsp_valid) break;
    end
    chk({tag, "_lat"}, 128'(n), 128'(LAT + 15));
    chk({tag, "_data"}, bi.rsp_data, exp);
    chk({tag, "_sel"}, 128'(selbad), 128'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {bi.rsp_valid, bi.req_ready}, 128'(2'b01));
    chk({tag, "_hold"}, bi.rsp_data, exp);
  endtask

  initial begin
    int n;
    int na;
    int nb;
    int c0;
    logic got_a;

    drop_valid();
    bi.req_key = 128'd0;  bi.req_block = 128'd0;  bi.req_decrypt = 1'b0;
    bi2.req_key = 128'd0; bi2.req_block = 128'd0; bi2.req_decrypt = 1'b0;

    // Reset values
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);

    // FIPS-197 encrypt plus write-trace checks for both word orders
    tr_adr.delete(); tr_dat.delete(); tr_cyc.delete();
    st_cyc.delete(); rd_cyc.delete();
    tr2_adr.delete(); tr2_dat.delete();
    run_job("enc", K, P, 1'b0, C);
    chk("trace_len", 128'(tr_dat.size()), 128'd8);
    chk("trace_w0", {tr_adr[0], tr_dat[0]}, 128'({1'b1, 32'h00010203}));
    chk("trace_w3", {tr_adr[3], tr_dat[3]}, 128'({1'b1, 32'h0c0d0e0f}));
    chk("trace_w4", {tr_adr[4], tr_dat[4]}, 128'({1'b0, 32'h00112233}));
    chk("trace_w7", {tr_adr[7], tr_dat[7]}, 128'({1'b0, 32'hccddeeff}));
    chk("trace_consec", 128'(tr_cyc[7] - tr_cyc[0]), 128'd7);
    chk("start_after_wr", 128'(st_cyc[0] - tr_cyc[7]), 128'd1);
    chk("rd_after_start", 128'(rd_cyc[0] - st_cyc[0]), 128'(LAT + 1));
    chk("kf0_w0", {tr2_adr[0], tr2_dat[0]}, 128'({1'b0, 32'h00112233}));
    chk("kf0_w4", {tr2_adr[4], tr2_dat[4]}, 128'({1'b1, 32'h00010203}));
    chk("kf0_w7", {tr2_adr[7], tr2_dat[7]}, 128'({1'b1, 32'h0c0d0e0f}));

    // Decrypt of the ciphertext
    run_job("dec", K, C, 1'b1, P);

    // Back-to-back: second job held on req_valid while busy
    c0 = rsp_cnt;
    n = 0; na = 0; nb = 0; got_a = 1'b0;
    present(K, P, 1'b0);
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bi.req_block = C;  bi.req_decrypt = 1'b1;
        bi2.req_block = C; bi2.req_decrypt = 1'b1;
      end
      if (bi.rsp_valid && !got_a) begin
        got_a = 1'b1;
        na = n;
        chk("b2b_a_data", bi.rsp_data, C);
      end else if (bi.rsp_valid && got_a) begin
        nb = n;
        break;
      end
      if (got_a && n == na + 1) chk("b2b_ready", 128'(bi.req_ready), 128'd1);
      if (got_a && n == na + 2) begin
        chk("b2b_taken", 128'(bi.req_ready), 128'd0);
        drop_valid();
      end
    end
    drop_valid();
    chk("b2b_a_lat", 128'(na), 128'(LAT + 15));
    chk("b2b_b_lat", 128'(nb), 128'(2 * (LAT + 15) + 1));
    chk("b2b_b_data", bi.rsp_data, P);
    repeat (4) @(negedge clk);
    chk("b2b_rsp_count", 128'(rsp_cnt - c0), 128'd2);

    // Reset in the middle of WAIT
    n = 0;
    present(K, P, 1'b0);
    while (n < 11) begin
      @(negedge clk);
      n++;
      if (n == 1) drop_valid();
    end
    chk("mid_busy", 128'(bi.busy), 128'd1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    reset = 1'b1;
    c0 = rsp_cnt;
    repeat (30) @(negedge clk);
    chk("mid_no_rsp", 128'(rsp_cnt - c0), 128'd0);
    run_job("post_rst", K, P, 1'b0, C);

    // Global bus rules
    repeat (2) @(negedge clk);
    chk("bus_released", 128'(zbad), 128'd0);
    chk("init_start_excl", 128'(overlap), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
